// File: rtl/data_ram_banked.sv
// Banked byte-lane data memory for the MEM stage: sized loads and stores over a valid/ready handshake.
// Optional feature macro: DATA_RAM_MISALIGN_EXC_EN (misaligned accesses fault instead of being aligned down).
module data_ram_banked #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  dbg_state
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int LB = $clog2(NB);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_accept;
    logic [2:0]            w_lane;
    logic [2:0]            w_lane_eff;
    logic [2:0]            w_low_mask;
    logic [3:0]            w_nbytes;
    logic [IW-1:0]         w_index;
    logic                  w_range_err;
    logic                  w_size_err;
    logic                  w_align_err;
    logic                  w_err;
    logic                  w_wr_en;
    logic [NB-1:0]         w_be;
    logic [DATA_WIDTH-1:0] w_wdata_sh;
    logic [DATA_WIDTH-1:0] w_word;
    logic [DATA_WIDTH-1:0] w_shift;
    logic [DATA_WIDTH-1:0] w_mask;
    logic                  w_sign;
    logic [DATA_WIDTH-1:0] w_load;
    logic [DATA_WIDTH-1:0] w_resp_data;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;

    // Handshake: a request transfers on any edge where req_valid && req_ready; a response
    // transfers on any edge where resp_valid && resp_ready, and resp_* hold steady until then.
    assign w_accept = req_valid && req_ready;

    assign w_lane      = 3'(req_addr[LB-1:0]);
    assign w_index     = req_addr[LB+IW-1:LB];
    assign w_range_err = (req_addr >> (LB + IW)) != '0;
    assign w_size_err  = (DATA_WIDTH == 32) && (req_size == 2'd3);

    always_comb begin
        case (req_size)
            2'd0:    w_low_mask = 3'd0;
            2'd1:    w_low_mask = 3'd1;
            2'd2:    w_low_mask = 3'd3;
            default: w_low_mask = 3'd7;
        endcase
    end

    assign w_nbytes = {1'b0, w_low_mask} + 4'd1;

`ifdef DATA_RAM_MISALIGN_EXC_EN
    assign w_lane_eff  = w_lane;
    assign w_align_err = (w_lane & w_low_mask) != 3'd0;
`else
    // Without the exception, aligning down keeps every access inside one word.
    assign w_lane_eff  = w_lane & ~w_low_mask;
    assign w_align_err = 1'b0;
`endif

    assign w_err   = w_range_err || w_size_err || w_align_err;
    assign w_wr_en = w_accept && req_we && !w_err && !rst;

    always_comb begin
        w_be = '0;
        for (int i = 0; i < NB; i++) begin
            w_be[i] = (i >= int'(w_lane_eff)) && (i < int'(w_lane_eff) + int'(w_nbytes));
        end
    end

    assign w_wdata_sh = req_wdata << {w_lane_eff, 3'b000};

    for (genvar g = 0; g < NB; g++) begin : g_bank
        logic [7:0] r_bank [DEPTH];

        always_ff @(posedge clk) begin
            if (w_wr_en && w_be[g]) begin
                r_bank[w_index] <= w_wdata_sh[8*g +: 8];
            end
        end

        assign w_word[8*g +: 8] = r_bank[w_index];
    end

    assign w_shift = w_word >> {w_lane_eff, 3'b000};

    always_comb begin
        w_mask = '0;
        w_sign = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (i < int'(w_nbytes)) begin
                w_mask[8*i +: 8] = 8'hFF;
            end
            if (i + 1 == int'(w_nbytes)) begin
                w_sign = w_shift[8*i + 7];
            end
        end
    end

    assign w_load      = (w_shift & w_mask) | ((req_signed && w_sign) ? ~w_mask : '0);
    assign w_resp_data = (req_we || w_err) ? '0 : w_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_rdata <= w_resp_data;
            r_err   <= w_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_RESP;
            S_RESP: if (resp_ready && !w_accept) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (r_state == S_IDLE) || resp_ready;
        resp_valid = (r_state == S_RESP);
        resp_rdata = r_rdata;
        resp_err   = r_err;
        dbg_state  = (r_state == S_RESP);
    end
endmodule

// File: doc/data_ram_banked.md
Name: data_ram_banked

Overview:
- Parametrised data memory for the MEM stage.
- Banked byte-lane storage of configurable width and depth, behind a valid/ready request and response handshake.
- Sized loads and stores (byte/half/word/dword) with sign or zero extension, address range checking and an error flag.
- Registered read path. One request per cycle when the response side is not back-pressured.

Parameters:
- DATA_WIDTH, 32, data path width in bits; legal values 32 or 64; lane count NB = DATA_WIDTH/8.
- ADDR_WIDTH, 32, byte address width.
- DEPTH, 1024, number of DATA_WIDTH-bit words; power of two.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  0 byte, 1 half, 2 word, 3 dword.
- req_signed  input  1  load extension: 1 sign, 0 zero; ignored for stores.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  DATA_WIDTH  store data, right-justified.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts the response.
- resp_rdata  output  DATA_WIDTH  load result, extended to DATA_WIDTH; 0 for stores and errors.
- resp_err  output  1  request faulted (range or alignment).

Behaviour:
- Reset values:
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, FSM=IDLE.
  - Memory contents are not reset and are retained across reset.
- Address split:
  - lane = req_addr[log2(NB)-1:0].
  - word index = req_addr[log2(NB)+log2(DEPTH)-1:log2(NB)].
  - Range error when any req_addr bit above the word index is nonzero.
- Size legality:
  - size 3 with DATA_WIDTH=32 is illegal and raises resp_err.
- Access width: 1, 2, 4 or 8 bytes.
- Handshake:
  - A request is accepted at edge N when req_valid && req_ready.
  - req_ready = (state==IDLE) || resp_ready.
  - Request fields are sampled only at acceptance.
- FSM:
  - IDLE -> RESP on acceptance.
  - RESP -> IDLE on resp_ready && !new acceptance.
  - RESP -> RESP on resp_ready && new acceptance (back-to-back).
  - RESP holds while !resp_ready, with resp_* stable.
- Store:
  - At edge N, write the accessed bytes into lanes lane..lane+width-1 of the indexed word, taking req_wdata[8*width-1:0] with the LSB byte in the lowest lane.
  - Other lanes are unchanged.
  - resp_valid=1 from cycle N+1, with resp_rdata=0.
- Load:
  - The word is read at edge N, and the selected bytes are shifted down, extended per req_signed and registered.
  - resp_valid=1 and resp_rdata are valid in cycle N+1; latency is 1 cycle.
- Error:
  - Store is suppressed (no lane written).
  - Load returns resp_rdata=0.
  - resp_err=1 alongside resp_valid.
- Read-after-write: a store accepted at edge N followed by a load to the same address accepted at N+1 returns the new data; no hazard is possible.
- Lane overflow: an access where lane+width > NB is handled per the Optional Feature.
- Reset mid-operation: a pending response is discarded (resp_valid→0), the FSM returns to IDLE, and a write already committed stays committed.

Optional Feature:
- Macro: DATA_RAM_MISALIGN_EXC_EN.
- Defined:
  - Misalignment is any access whose lane is not a multiple of width.
  - A misaligned access raises resp_err=1 with Error behaviour (store suppressed, load data 0).
- Undefined:
  - No alignment error.
  - Low address bits below the access width are forced to zero (aligned down) before lane selection.
  - resp_err reflects range/size errors only.

Test Plan:
- Reset, then a word store of 0xDEADBEEF at 0x10, then a word load at 0x10 -> resp_valid one cycle after acceptance, resp_rdata=0xDEADBEEF, resp_err=0.
- Byte store 0x80 at 0x13, then signed byte load at 0x13 -> 0xFFFFFF80; unsigned byte load -> 0x00000080; word load at 0x10 -> 0x80ADBEEF.
- Half store 0x1234 at 0x22 over a word previously holding 0xAAAAAAAA; word load at 0x20 -> 0x1234AAAA.
- resp_ready held 0 for 3 cycles after a load -> resp_valid and resp_rdata stable, req_ready=0; then resp_ready=1 with a queued request -> back-to-back acceptance and no lost response.
- Load at word index DEPTH (byte address NB*DEPTH) -> resp_err=1, resp_rdata=0; store to the same address leaves memory unchanged.
- Word load at 0x11:
  - With DATA_RAM_MISALIGN_EXC_EN defined -> resp_err=1.
  - Without it -> resp_err=0, data equals a word load at 0x10.
  - Additionally, assert rst while resp_valid=1 -> resp_valid=0 immediately and previously stored data is intact.
